// File: rtl/binary_maxpool_packer.sv
// binary_maxpool_packer: 2x2/stride-2 OR pooling of a raster binary stream,
// LSB-first word packing, FWFT word FIFO with valid/ready output.
// Ports: clk, rst (sync, active-low), frame_start, in_valid, in_bit,
//   out_valid/out_ready/out_data/out_last (FIFO head), busy, frame_done,
//   overflow (sticky word drop).
module binary_maxpool_packer #(
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  parameter int WORD_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int HW = IMG_W / 2;
  localparam int XW = (HW > 1) ? $clog2(HW) : 1;
  localparam int PW = $clog2(WORD_W) + 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    FLUSH
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic              h;
  logic [HW-1:0]     lbuf;
  logic [WORD_W-1:0] pack;
  logic [PW-1:0]     pcnt;

  logic              pw_vld;
  logic [WORD_W-1:0] pw_data;
  logic              pw_last;

  logic              acc;
  logic [CW-1:0]     col_e;
  logic [RW-1:0]     row_e;
  logic [XW-1:0]     hx;
  logic              pair;
  logic              pooled;
  logic              pool_en;
  logic              last_px;
  logic              word_full;
  logic [WORD_W-1:0] word_nx;

  // frame_start restarts at (0,0) and the same-cycle pixel counts as (0,0)
  assign acc     = in_valid & (frame_start | (state == ACTIVE));
  assign col_e   = frame_start ? '0 : col;
  assign row_e   = frame_start ? '0 : row;
  assign hx      = XW'(col_e >> 1);
  assign pair    = h | in_bit;
  assign pooled  = lbuf[hx] | pair;
  assign pool_en = acc & col_e[0] & row_e[0];
  assign last_px = acc && (row_e == RW'(IMG_H - 1))
                   && (col_e == CW'(IMG_W - 1));
  assign word_nx = pack | (WORD_W'(pooled) << pcnt);
  assign word_full = pool_en && (pcnt == PW'(WORD_W - 1));

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = IDLE;
      ACTIVE:  if (last_px) state_nx = FLUSH;
      FLUSH:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (frame_start) state_nx = ACTIVE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col        <= '0;
      row        <= '0;
      h          <= 1'b0;
      lbuf       <= '0;
      pack       <= '0;
      pcnt       <= '0;
      pw_vld     <= 1'b0;
      pw_data    <= '0;
      pw_last    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pw_vld     <= word_full;
      pw_data    <= word_nx;
      pw_last    <= last_px;
      frame_done <= 1'b0;
      if (frame_start) begin
        row  <= '0;
        col  <= CW'(acc);
        pack <= '0;
        pcnt <= '0;
        busy <= 1'b1;
        if (acc) h <= in_bit;
      end else begin
        if (acc) begin
          if (!col[0])      h          <= in_bit;
          else if (!row[0]) lbuf[hx]   <= pair;
          if (col == CW'(IMG_W - 1)) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
          if (pool_en) begin
            if (word_full) begin
              pack <= '0;
              pcnt <= '0;
            end else begin
              pack <= word_nx;
              pcnt <= pcnt + 1'b1;
            end
          end
        end
        if (state == FLUSH) begin
          row        <= '0;
          col        <= '0;
          pack       <= '0;
          pcnt       <= '0;
          busy       <= 1'b0;
          frame_done <= 1'b1;
        end
      end
    end
  end

  // full-word pushes are registered; the FLUSH partial push is direct,
  // and the two never coincide (a full final word leaves pcnt at 0)
  logic            flush_push;
  logic            wr_en;
  logic [WORD_W:0] wr_data;

  assign flush_push = (state == FLUSH) && (pcnt != '0) && !frame_start;
  assign wr_en      = pw_vld | flush_push;
  assign wr_data    = pw_vld ? {pw_last, pw_data} : {1'b1, pack};

  logic [WORD_W:0] mem [FIFO_DEPTH];
  logic [AW-1:0]   rp, wp;
  logic [AW:0]     cnt;
  logic            full, pop, push_ok;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (cnt == (AW + 1)'(FIFO_DEPTH));
  assign out_valid = (cnt != '0);
  assign pop       = out_valid & out_ready;
  assign push_ok   = wr_en & (~full | pop);
  assign out_data  = out_valid ? mem[rp][WORD_W-1:0] : '0;
  assign out_last  = out_valid & mem[rp][WORD_W];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rp       <= '0;
      wp       <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wp <= nxt(wp);
      if (pop)     rp <= nxt(rp);
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (frame_start)              overflow <= 1'b0;
      else if (wr_en & full & ~pop) overflow <= 1'b1;
    end
  end

endmodule
